// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding, the
// default operand width and the iteration-counter width.
package restoring_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH_DEF = 16;
  localparam int DIV_CNT_W_DEF = $clog2(DIV_WIDTH_DEF) + 1;

  // Counter width for an arbitrary operand width; one spare bit guarantees
  // the count to WIDTH-1 can never wrap.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/restoring_divider_cla_subtractor.sv
// cla_subtractor: computes a - b as a + ~b + 1 using flattened
// carry-lookahead generate/propagate terms.
// Ports:
//   a_i      [W-1:0]  minuend
//   b_i      [W-1:0]  subtrahend
//   diff_o   [W-1:0]  difference (mod 2^W)
//   borrow_o          1 when b_i > a_i (no carry out of the top bit)
module cla_subtractor #(
  parameter int W = 17
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);

  logic [W-1:0] b_n;
  logic [W-1:0] gen;
  logic [W-1:0] prop;
  logic [W:0]   carry;

  assign b_n  = ~b_i;
  assign gen  = a_i & b_n;
  assign prop = a_i ^ b_n;

  // Each carry is the full sum-of-products over lower bits, with the
  // implicit +1 acting as carry-in, so no carry depends on another carry.
  always_comb begin : carry_lookahead
    logic cy;
    logic pp;
    carry    = '0;
    carry[0] = 1'b1;
    cy       = 1'b0;
    pp       = 1'b1;
    for (int i = 0; i < W; i++) begin
      cy = 1'b0;
      pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        cy = cy | (pp & gen[j]);
        pp = pp & prop[j];
      end
      cy = cy | pp;
      carry[i+1] = cy;
    end
  end

  assign diff_o   = prop ^ carry[W-1:0];
  assign borrow_o = ~carry[W];

endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: unsigned WIDTH-bit restoring division, one quotient
// bit per clock, MSB first.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             request; sampled only while idle
//   dividend, divisor operands, latched on the accepting edge
//   busy              high while iterating
//   done              one-cycle result-valid pulse
//   quotient,
//   remainder,
//   div_by_zero       registered results, held until the next completion
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // dvd_q shifts out dividend bits at the top while quotient bits enter at
  // the bottom; after WIDTH steps it holds the quotient.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_res_q, quo_res_d;
  logic [WIDTH-1:0] rem_res_q, rem_res_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial_a;
  logic [WIDTH:0]   trial_b;
  logic [WIDTH:0]   trial_diff;
  logic             trial_borrow;
  logic             step_fits;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  assign trial_a = {rem_q, dvd_q[WIDTH-1]};
  assign trial_b = {1'b0, dvs_q};

  cla_subtractor #(
    .W (WIDTH + 1)
  ) u_sub (
    .a_i      (trial_a),
    .b_i      (trial_b),
    .diff_o   (trial_diff),
    .borrow_o (trial_borrow)
  );

  // The partial remainder stays below the divisor, so a successful trial
  // always leaves the difference MSB clear; both flags agree on "fits".
  assign step_fits = ~trial_borrow & ~trial_diff[WIDTH];
  assign step_rem  = step_fits ? trial_diff[WIDTH-1:0] : trial_a[WIDTH-1:0];
  assign step_quo  = (dvd_q << 1) | WIDTH'(step_fits);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_res_q <= '0;
      rem_res_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quo_res_q <= quo_res_d;
      rem_res_q <= rem_res_d;
      dbz_q     <= dbz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_res_d = quo_res_q;
    rem_res_d = rem_res_q;
    dbz_d     = dbz_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          dvd_d = dividend;
          dvs_d = divisor;
          rem_d = '0;
          cnt_d = '0;
          if (divisor == '0) begin
            // No iteration: results are defined directly.
            state_d   = ST_DONE;
            quo_res_d = '1;
            rem_res_d = dividend;
            dbz_d     = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        dvd_d = step_quo;
        rem_d = step_rem;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d   = ST_DONE;
          quo_res_d = step_quo;
          rem_res_d = step_rem;
          dbz_d     = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quo_res_q;
  assign remainder   = rem_res_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
module tb_restoring_divider;

  localparam int W = 16;
  localparam logic [W-1:0] ONES = '1;

  logic         clk;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           acc;
  } exp_t;

  exp_t sb[$];

  restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic finish_up();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Reference: plain integer division semantics.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    e.acc = 0;
    if (b == 0) begin
      e.q = ONES;
      e.r = a;
      e.dbz = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: compares every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && done) begin
        checks++;
        errors++;
        $display("FAIL busy_done_overlap: got busy=1 done=1 expected not both");
      end
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending operation");
        end else begin
          exp_t e;
          longint recon;
          e = sb.pop_front();
          check("latency", 64'(edge_cnt - e.acc), (e.b == 0) ? 64'd0 : 64'(W));
          check("quotient", 64'(quotient), 64'(e.q));
          check("remainder", 64'(remainder), 64'(e.r));
          check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
          if (e.b != 0) begin
            recon = longint'(quotient) * longint'(e.b) + longint'(remainder);
            check("identity", 64'((recon == longint'(e.a)) && (remainder < e.b)), 64'd1);
          end
        end
      end
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit junk);
    exp_t e;
    bit seen;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e = model(a, b);
    e.acc = edge_cnt + 1;
    sb.push_back(e);
    seen = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        seen = 1;
        break;
      end
      check("busy_run", 64'(busy), 64'd1);
      if (junk && k == 2) begin
        start    = 1'b1;
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles expected done", W + 4);
      finish_up();
    end
    @(negedge clk);
  endtask

  // start held high for n operations: acceptances every W+2 edges.
  task automatic b2b(input logic [W-1:0] a, input logic [W-1:0] b, input int n);
    exp_t e;
    int base;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    base = edge_cnt + 1;
    for (int i = 0; i < n; i++) begin
      e = model(a, b);
      e.acc = base + i * (W + 2);
      sb.push_back(e);
    end
    repeat ((n - 1) * (W + 2) + 1) @(negedge clk);
    start = 1'b0;
    repeat (W + 1) @(negedge clk);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return ONES;
      2: return W'($urandom_range(1, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_remainder", 64'(remainder), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;

    do_op(16'd100, 16'd7, 0);
    do_op(16'hFFFF, 16'd1, 0);
    do_op(16'd3, 16'd10, 0);
    do_op(16'd5, 16'd0, 0);
    do_op(16'd100, 16'd7, 1);
    do_op(16'd0, 16'd9, 1);
    b2b(16'd1000, 16'd3, 3);

    // Reset in the middle of an operation.
    @(negedge clk);
    dividend = 16'd1000;
    divisor  = 16'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_quotient", 64'(quotient), 64'd0);
    check("abort_remainder", 64'(remainder), 64'd0);
    check("abort_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 2) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 64'd0);
    end
    do_op(16'd1000, 16'd3, 0);

    for (int i = 0; i < 1500; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = pick_operand();
      b = pick_operand();
      do_op(a, b, (i % 4) == 0);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    finish_up();
  end

endmodule
